sort_window_feed: RTL and testbench



---
 rtl/sort_window_feed.sv | 77 +++++++
 tb/tb_sort_window_feed.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_window_feed.sv
// Sample window front-end for the compare-and-swap sorter: shifts accepted samples into a
// NUM_INPUTS-deep window and registers the sorter's ordered result behind a valid/ready output.
module sort_window_feed #(
    parameter int unsigned NUM_INPUTS = 5,
    parameter int unsigned WIDTH      = 3,
    parameter bit          TUMBLE     = 1'b0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WIDTH-1:0]                     in_data,
    input  logic                                 flush,
    output logic [NUM_INPUTS-1:0][WIDTH-1:0]     win_data,
    input  logic [NUM_INPUTS-1:0][WIDTH-1:0]     sorted_in,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NUM_INPUTS-1:0][WIDTH-1:0]     out_sorted
);

    localparam int unsigned     CNT_W    = $clog2(NUM_INPUTS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_INPUTS);

    logic [NUM_INPUTS-1:0][WIDTH-1:0] win;
    logic [CNT_W-1:0]                 cnt;
    logic [CNT_W-1:0]                 cnt_base;
    logic [CNT_W-1:0]                 cnt_next;
    logic                             pend;
    logic                             pend_next;
    logic                             acc;
    logic                             cap;

    assign win_data = win;

    // Capture frees the pending slot in the same cycle, so a new sample may be accepted alongside it.
    always_comb begin
        cap      = pend & (~out_valid | out_ready);
        in_ready = ~flush & (~pend | cap);
        acc      = in_valid & in_ready;
    end

    // Tumbling mode restarts the fill count on capture before any same-edge accept is counted.
    always_comb begin
        cnt_base = (TUMBLE && cap) ? '0 : cnt;
        cnt_next = cnt_base;
        if (acc && (cnt_base != CNT_FULL)) begin
            cnt_next = cnt_base + 1'b1;
        end
        pend_next = pend & ~cap;
        if (acc && (cnt_next == CNT_FULL)) begin
            pend_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            win        <= '0;
            cnt        <= '0;
            pend       <= 1'b0;
            out_valid  <= 1'b0;
            out_sorted <= '0;
        end else begin
            if (acc) begin
                win <= {win[NUM_INPUTS-2:0], in_data};
            end
            cnt  <= cnt_next;
            pend <= pend_next;
            if (cap) begin
                out_sorted <= sorted_in;
                out_valid  <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sort_window_feed.sv
// Bench for sort_window_feed: sliding and tumbling instances share one stimulus stream,
// with a behavioural sorter and window model kept alongside.
module tb_sort_window_feed;

    localparam int unsigned N = 5;
    localparam int unsigned W = 3;
    typedef logic [N-1:0][W-1:0] vec_t;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, out_ready;
    logic [W-1:0] in_data;
    logic [1:0] in_ready, out_valid;
    vec_t       win_data [2];
    vec_t       sorted_in [2];
    vec_t       out_sorted [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sort_window_feed #(.NUM_INPUTS(N), .WIDTH(W), .TUMBLE(1'b0)) u_slide (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
        .flush(flush), .win_data(win_data[0]), .sorted_in(sorted_in[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_sorted(out_sorted[0])
    );

    sort_window_feed #(.NUM_INPUTS(N), .WIDTH(W), .TUMBLE(1'b1)) u_tumble (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
        .flush(flush), .win_data(win_data[1]), .sorted_in(sorted_in[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_sorted(out_sorted[1])
    );

    function automatic vec_t sort_desc(vec_t v);
        int   a [N];
        int   t;
        vec_t r;
        for (int unsigned i = 0; i < N; i++) a[i] = int'(v[i]);
        for (int unsigned i = 0; i < N - 1; i++)
            for (int unsigned j = 0; j < N - 1 - i; j++)
                if (a[j] < a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        for (int unsigned i = 0; i < N; i++) r[i] = W'(a[i]);
        return r;
    endfunction

    // Stand-in for the CAS sorter feeding each instance.
    always_comb begin
        sorted_in[0] = sort_desc(win_data[0]);
        sorted_in[1] = sort_desc(win_data[1]);
    end

    function automatic vec_t mk(int a0, int a1, int a2, int a3, int a4);
        vec_t v;
        v[0] = W'(a0); v[1] = W'(a1); v[2] = W'(a2); v[3] = W'(a3); v[4] = W'(a4);
        return v;
    endfunction

    // Reference model: window contents, fill count, pending flag and output register per instance.
    vec_t mw [2];
    vec_t mo [2];
    int   mc [2];
    bit   mp [2];
    bit   mv [2];

    function automatic bit m_cap(int unsigned i);
        return mp[i] && (!mv[i] || out_ready);
    endfunction

    function automatic bit m_rdy(int unsigned i);
        return !flush && (!mp[i] || m_cap(i));
    endfunction

    task automatic tick();
        bit cap, acc;
        for (int unsigned i = 0; i < 2; i++) begin
            cap = m_cap(i);
            acc = in_valid && m_rdy(i);
            if (rst || flush) begin
                mw[i] = '0; mo[i] = '0; mc[i] = 0; mp[i] = 1'b0; mv[i] = 1'b0;
            end else begin
                if (cap) begin
                    mo[i] = sort_desc(mw[i]);
                    mv[i] = 1'b1;
                    mp[i] = 1'b0;
                    if (i == 1) mc[i] = 0;
                end else if (mv[i] && out_ready) begin
                    mv[i] = 1'b0;
                end
                if (acc) begin
                    mw[i] = {mw[i][N-2:0], in_data};
                    if (mc[i] < int'(N)) mc[i]++;
                    if (mc[i] == int'(N)) mp[i] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit r, bit f, bit v, int d, bit o);
        rst = r; flush = f; in_valid = v; in_data = W'(d); out_ready = o;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 0, 1'b1);
        tick();
    endtask

    task automatic fill_35712(bit o);
        int vals [5] = '{3, 7, 1, 5, 2};
        for (int unsigned k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 1'b1, vals[k], o);
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
        n_checks++;
        if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready[0]); end
        n_checks++;
        if (out_valid !== 2'b00) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 00", out_valid); end
        n_checks++;
        if (out_sorted[0] !== vec_t'(0)) begin n_fail++; $display("FAIL reset_out_sorted: got %h expected 0", out_sorted[0]); end
        n_checks++;
        if (win_data[0] !== vec_t'(0)) begin n_fail++; $display("FAIL reset_win_data: got %h expected 0", win_data[0]); end
    endtask

    task automatic test_fill();
        do_reset();
        fill_35712(1'b1);
        n_checks++;
        if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL fill_latency_early: got %b expected 0", out_valid[0]); end
        drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
        tick();
        n_checks++;
        if (out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL fill_latency: got %b expected 1", out_valid[0]); end
        n_checks++;
        if (out_sorted[0] !== mk(7, 5, 3, 2, 1)) begin
            n_fail++; $display("FAIL fill_result: got %h expected %h", out_sorted[0], mk(7, 5, 3, 2, 1));
        end
        n_checks++;
        if (out_sorted[1] !== mk(7, 5, 3, 2, 1)) begin
            n_fail++; $display("FAIL fill_result_tumble: got %h expected %h", out_sorted[1], mk(7, 5, 3, 2, 1));
        end
    endtask

    task automatic test_slide();
        drive(1'b0, 1'b0, 1'b1, 6, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 4, 1'b1);
        tick();
        n_checks++;
        if (out_valid[0] !== 1'b1 || out_sorted[0] !== mk(7, 6, 5, 2, 1)) begin
            n_fail++; $display("FAIL slide_result: got v=%b %h expected v=1 %h", out_valid[0], out_sorted[0], mk(7, 6, 5, 2, 1));
        end
        for (int unsigned k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, 1'b1, int'($urandom_range(0, 7)), 1'b1);
            n_checks++;
            if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL slide_in_ready: got %b expected 1", in_ready[0]); end
            tick();
            n_checks++;
            if (out_valid[0] !== 1'b1 || out_sorted[0] !== mo[0]) begin
                n_fail++; $display("FAIL slide_throughput: got v=%b %h expected v=1 %h", out_valid[0], out_sorted[0], mo[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        int extra = 0;
        do_reset();
        fill_35712(1'b1);
        drive(1'b0, 1'b0, 1'b1, 6, 1'b0);
        n_checks++;
        if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bp_one_more: got %b expected 1", in_ready[0]); end
        tick();
        for (int unsigned k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b1, 4, 1'b0);
            if (in_ready[0] === 1'b1) extra++;
            tick();
        end
        n_checks++;
        if (extra !== 0) begin n_fail++; $display("FAIL bp_stall: got %0d extra accepts expected 0", extra); end
        drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
        n_checks++;
        if (out_valid[0] !== 1'b1 || out_sorted[0] !== mk(7, 5, 3, 2, 1)) begin
            n_fail++; $display("FAIL bp_hold: got v=%b %h expected v=1 %h", out_valid[0], out_sorted[0], mk(7, 5, 3, 2, 1));
        end
        tick();
        n_checks++;
        if (out_valid[0] !== 1'b1 || out_sorted[0] !== mk(7, 6, 5, 2, 1)) begin
            n_fail++; $display("FAIL bp_second: got v=%b %h expected v=1 %h", out_valid[0], out_sorted[0], mk(7, 6, 5, 2, 1));
        end
        n_checks++;
        if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b expected 1", in_ready[0]); end
        tick();
        n_checks++;
        if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b expected 0", out_valid[0]); end
    endtask

    task automatic test_tumble();
        int   vals [10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
        int   fed = 0;
        vec_t got [$];
        do_reset();
        for (int unsigned c = 0; c < 40; c++) begin
            if (fed < 10) drive(1'b0, 1'b0, 1'b1, vals[fed], 1'b1);
            else          drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
            if (out_valid[1] === 1'b1) got.push_back(out_sorted[1]);
            if (fed < 10 && in_ready[1] === 1'b1) fed++;
            tick();
        end
        n_checks++;
        if (fed != 10) begin n_fail++; $display("FAIL tumble_fed: got %0d expected 10", fed); end
        n_checks++;
        if (got.size() != 2) begin n_fail++; $display("FAIL tumble_count: got %0d expected 2", got.size()); end
        if (got.size() > 0) begin
            n_checks++;
            if (got[0] !== mk(5, 4, 3, 2, 1)) begin n_fail++; $display("FAIL tumble_first: got %h expected %h", got[0], mk(5, 4, 3, 2, 1)); end
        end
        if (got.size() > 1) begin
            n_checks++;
            if (got[1] !== mk(7, 6, 2, 1, 0)) begin n_fail++; $display("FAIL tumble_second: got %h expected %h", got[1], mk(7, 6, 2, 1, 0)); end
        end
    endtask

    task automatic test_flush();
        int   fed = 0;
        vec_t got [$];
        do_reset();
        for (int unsigned k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b1, 4, 1'b1);
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 7, 1'b1);
        n_checks++;
        if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 0", in_ready[0]); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
        n_checks++;
        if (win_data[0] !== vec_t'(0)) begin n_fail++; $display("FAIL flush_win: got %h expected 0", win_data[0]); end
        for (int unsigned c = 0; c < 30; c++) begin
            if (fed < 5) drive(1'b0, 1'b0, 1'b1, fed + 1, 1'b1);
            else         drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
            if (out_valid[0] === 1'b1) got.push_back(out_sorted[0]);
            if (fed < 5 && in_ready[0] === 1'b1) fed++;
            tick();
        end
        n_checks++;
        if (fed != 5 || got.size() != 1) begin
            n_fail++; $display("FAIL flush_count: got fed=%0d results=%0d expected fed=5 results=1", fed, got.size());
        end
        if (got.size() > 0) begin
            n_checks++;
            if (got[0] !== mk(5, 4, 3, 2, 1)) begin n_fail++; $display("FAIL flush_result: got %h expected %h", got[0], mk(5, 4, 3, 2, 1)); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill_35712(1'b1);
        drive(1'b0, 1'b0, 1'b1, 6, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
        n_checks++;
        if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
            n_fail++; $display("FAIL rmid_setup: got v=%b rdy=%b expected v=1 rdy=0", out_valid[0], in_ready[0]);
        end
        drive(1'b1, 1'b0, 1'b1, 5, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
        n_checks++;
        if (out_valid[0] !== 1'b0 || out_sorted[0] !== vec_t'(0) || win_data[0] !== vec_t'(0) || in_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL rmid_clear: got v=%b out=%h win=%h rdy=%b expected 0 0 0 1",
                               out_valid[0], out_sorted[0], win_data[0], in_ready[0]);
        end
        for (int unsigned k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b1, int'(k), 1'b1);
            tick();
        end
        for (int unsigned k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
            tick();
        end
        n_checks++;
        if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL rmid_no_early: got %b expected 0", out_valid[0]); end
        drive(1'b0, 1'b0, 1'b1, 6, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
        tick();
        n_checks++;
        if (out_valid[0] !== 1'b1 || out_sorted[0] !== mk(6, 3, 2, 1, 0)) begin
            n_fail++; $display("FAIL rmid_refill: got v=%b %h expected v=1 %h", out_valid[0], out_sorted[0], mk(6, 3, 2, 1, 0));
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int unsigned c = 0; c < 500; c++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 7)), $urandom_range(0, 2) != 0);
            for (int unsigned i = 0; i < 2; i++) begin
                n_checks++;
                if (in_ready[i] !== m_rdy(i)) begin n_fail++; $display("FAIL rand_in_ready[%0d] cyc %0d: got %b expected %b", i, c, in_ready[i], m_rdy(i)); end
                n_checks++;
                if (out_valid[i] !== mv[i]) begin n_fail++; $display("FAIL rand_out_valid[%0d] cyc %0d: got %b expected %b", i, c, out_valid[i], mv[i]); end
                n_checks++;
                if (out_sorted[i] !== mo[i]) begin n_fail++; $display("FAIL rand_out_sorted[%0d] cyc %0d: got %h expected %h", i, c, out_sorted[i], mo[i]); end
                n_checks++;
                if (win_data[i] !== mw[i]) begin n_fail++; $display("FAIL rand_win_data[%0d] cyc %0d: got %h expected %h", i, c, win_data[i], mw[i]); end
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_slide();
        test_backpressure();
        test_tumble();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
